alureg_seq: RTL
===============

// Module: alureg_seq
// PURPOSE
// Parametrised successor to the 8-bit ALU/register-file block: a REGCOUNT-entry
// register file with integrated ALU and a byte-serial micro-sequencer for
// register-pair ops (DAD/INX/DCX) with carry chaining between bytes.
// Driven by the control unit over an op_stb/op_rdy handshake.
// Data width is generic; F (flags) and A (accumulator) are the top two entries.
// PARAMETERS
// DATASIZE  8  register/ALU width in bits, must be >= 8
// REGSBITS  3  register address bits; REGCOUNT = 2**REGSBITS, REGPAIRS = REGCOUNT/2
// REG_F     REGCOUNT-2  flag register index
// REG_A     REGCOUNT-1  accumulator index
// PORTS
// clk        in   1         clock, all state on rising edge
// rst_       in   1         reset, asynchronous, active-low
// op_stb     in   1         op request; accepted when op_stb & op_rdy
// op_cod     in   4         opcode (see BEHAVIOUR)
// op_dst     in   REGSBITS  destination register (MOV/INR/DCR)
// op_src     in   REGSBITS  source reg; pair ops use op_src[REGSBITS-1:1]
// op_imm     in   DATASIZE  immediate operand
// op_uim     in   1         1 = op2 from op_imm instead of op_src
// ext_wr     in   1         external byte load (bus data), honoured only in IDLE
// ext_sel    in   REGSBITS  external load target
// ext_dat    in   DATASIZE  external load data
// rd_sel     in   REGSBITS  async read port select
// rd_dat     out  DATASIZE  regs[rd_sel], combinational
// flag_q     out  DATASIZE  regs[REG_F]
// op_rdy     out  1         sequencer IDLE, may accept op
// op_done    out  1         1-cycle pulse in the cycle the final write occurs
// BEHAVIOUR
// - Reset: all registers 0, state IDLE, op_rdy=1, op_done=0. Reset mid-op aborts;
//   partial pair results are discarded by the clear.
// - FSM IDLE -> EXLO -> (pair op ? EXHI) -> IDLE. Op latched on accept edge;
//   byte op writes at end of EXLO (latency 1), pair op low byte at EXLO, high at EXHI (latency 2).
//   op_done high during last EX state; op_rdy low in EXLO/EXHI. Back-to-back ops allowed
//   (op_stb accepted in cycle after op_done).
// - op_stb and ext_wr same IDLE cycle: op_stb wins, ext_wr dropped. ext_wr while busy ignored.
// - Byte ALU (op1=A, op2=reg/imm): 0 ADD 1 ADC 2 SUB 3 SBB 4 AND 5 XOR 6 OR 7 CMP.
//   Result to A except CMP (flags only). Width DATASIZE, carry = bit DATASIZE out; borrow sets C.
// - 8 MOV dst<=op2, no flags. 9 INR / 10 DCR dst, wraps, all flags except C.
// - 11 DAD: HL pair (REGPAIRS-2) += pair; low byte first, carry chained; only C updated.
// - 12 INX / 13 DCX pair: byte-serial, wraps all-ones<->0, no flags.
// - Pair index REGPAIRS-1 (F:A) for ops 11-13: no write, op_done still pulses.
// - 14 DAA (see CONFIGURATION). 15 reserved: NOP, op_done pulses after 1 cycle.
// - Flags: S=bit DATASIZE-1, Z=bit DATASIZE-2, AC=bit 4 (carry out of bit 3), P=bit 2
//   (even parity of result), C=bit 0; other bits always 0. Logic ops clear C, AC.
// - Writes to REG_F by MOV/ext_wr are masked to the flag bits.
// - Pair byte order: even index = high byte, odd = low byte.
// CONFIGURATION
// ALUREG_SEQ_DAA_EN defined: op 14 decimal-adjusts A per nibble (+6 if nibble>9 or
//   carry-in), updates S Z AC P C, 1-cycle. Undefined: op 14 behaves as op 15 (NOP),
//   A and F unchanged.
// TESTING
// - Reset: rst_=0 mid-DAD -> all regs 0, op_rdy=1, op_done=0 on release.
// - A=0x7F, ADD imm 0x01 -> A=0x80, F: S=1 Z=0 AC=1 P=0 C=0, op_done 1 cycle after accept.
// - H:L=0x12FF, B:C=0x0001, DAD pair 0 -> H:L=0x1300, C=0, op_done 2 cycles after accept, S/Z/P unchanged.
// - D:E=0xFFFF INX pair 1 -> 0x0000, F unchanged; DCX -> 0xFFFF.
// - op_stb & ext_wr same cycle -> only op executes; ext_wr during busy -> target unchanged.
// - A=0x9B, DAA -> EN: A=0x01, C=1, AC=1; without EN: A=0x9B, F unchanged.

Source files
------------

// File: rtl/alureg_seq.sv
`default_nettype none
// ============================================================================
// Module   : alureg_seq
// Purpose  : REGCOUNT-entry register file with an integrated byte ALU and a
//            byte-serial sequencer for register-pair operations (DAD/INX/DCX).
//            Pair operations run low byte first and carry into the high byte.
//            F (flags) and A (accumulator) are the top two register entries.
// Ports    : clk_i            clock, all state on rising edge
//            rst_ni           asynchronous active-low reset
//            op_stb_i         op request, accepted when op_stb_i & op_rdy_o
//            op_cod_i         opcode
//            op_dst_i         destination register (MOV/INR/DCR)
//            op_src_i         source register; pair ops use the upper bits
//            op_imm_i         immediate operand
//            op_uim_i         1 = second operand taken from op_imm_i
//            ext_wr_i         external register load, honoured only when idle
//            ext_sel_i        external load target
//            ext_dat_i        external load data
//            rd_sel_i         asynchronous read port select
//            rd_dat_o         regs[rd_sel_i]
//            flag_q_o         regs[REG_F]
//            op_rdy_o         sequencer idle, may accept an op
//            op_done_o        high in the cycle the final write occurs
// Options  : ALUREG_SEQ_DAA_EN  when defined, opcode 14 is decimal adjust of A;
//                               otherwise opcode 14 is a NOP.
// Revision : 1.0  initial release
// ============================================================================
module alureg_seq #(
    parameter int DATASIZE = 8,
    parameter int REGSBITS = 3,
    parameter int REG_F    = (2**REGSBITS) - 2,
    parameter int REG_A    = (2**REGSBITS) - 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                op_stb_i,
    input  logic [3:0]          op_cod_i,
    input  logic [REGSBITS-1:0] op_dst_i,
    input  logic [REGSBITS-1:0] op_src_i,
    input  logic [DATASIZE-1:0] op_imm_i,
    input  logic                op_uim_i,
    input  logic                ext_wr_i,
    input  logic [REGSBITS-1:0] ext_sel_i,
    input  logic [DATASIZE-1:0] ext_dat_i,
    input  logic [REGSBITS-1:0] rd_sel_i,
    output logic [DATASIZE-1:0] rd_dat_o,
    output logic [DATASIZE-1:0] flag_q_o,
    output logic                op_rdy_o,
    output logic                op_done_o
);
    localparam int REGCOUNT = 2**REGSBITS;
    localparam int REGPAIRS = REGCOUNT / 2;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_XOR = 4'd5,  OP_OR  = 4'd6,  OP_CMP = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8,  OP_INR = 4'd9,  OP_DCR = 4'd10, OP_DAD = 4'd11;
    localparam logic [3:0] OP_INX = 4'd12, OP_DCX = 4'd13, OP_DAA = 4'd14;

    localparam logic [REGSBITS-1:0] IDX_F   = REGSBITS'(REG_F);
    localparam logic [REGSBITS-1:0] IDX_A   = REGSBITS'(REG_A);
    localparam logic [REGSBITS-1:0] IDX_H   = REGSBITS'(REGCOUNT - 4);
    localparam logic [REGSBITS-1:0] IDX_L   = REGSBITS'(REGCOUNT - 3);
    localparam logic [REGSBITS-2:0] PAIR_FA = (REGSBITS-1)'(REGPAIRS - 1);

    // S, Z, AC, P, C positions; every other flag bit reads as zero.
    localparam logic [DATASIZE-1:0] FLAG_MASK = (DATASIZE'(1) << (DATASIZE-1))
                                              | (DATASIZE'(1) << (DATASIZE-2))
                                              | DATASIZE'(8'h15);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXLO = 2'd1, S_EXHI = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [DATASIZE-1:0] regs_q [REGCOUNT];
    logic [3:0]          cod_q;
    logic [REGSBITS-1:0] dst_q, src_q;
    logic [DATASIZE-1:0] imm_q;
    logic                uim_q;
    logic                carry_q, carry_d;

    logic                wr_en, fl_en;
    logic [REGSBITS-1:0] wr_idx;
    logic [DATASIZE-1:0] wr_dat, fl_dat;
    logic [DATASIZE:0]   lo_sum, hi_sum;

    function automatic logic [DATASIZE-1:0] mk_flags(input logic [DATASIZE-1:0] r,
                                                     input logic ac, input logic c);
        logic [DATASIZE-1:0] f;
        f             = '0;
        f[DATASIZE-1] = r[DATASIZE-1];
        f[DATASIZE-2] = (r == '0);
        f[4]          = ac;
        f[2]          = ~^r;
        f[0]          = c;
        return f;
    endfunction

    // Operand views of the latched op. Even pair index is the high byte.
    logic [DATASIZE-1:0] acc, flg, op2, dst_val, lo_val, hi_val;
    logic [REGSBITS-2:0] pair;
    logic [REGSBITS-1:0] idx_hi, idx_lo;
    logic                pair_fa, is_pair, accept;

    assign acc     = regs_q[IDX_A];
    assign flg     = regs_q[IDX_F];
    assign op2     = uim_q ? imm_q : regs_q[src_q];
    assign dst_val = regs_q[dst_q];
    assign pair    = src_q[REGSBITS-1:1];
    assign idx_hi  = {pair, 1'b0};
    assign idx_lo  = {pair, 1'b1};
    assign lo_val  = regs_q[idx_lo];
    assign hi_val  = regs_q[idx_hi];
    assign pair_fa = (pair == PAIR_FA);
    assign is_pair = (cod_q == OP_DAD) || (cod_q == OP_INX) || (cod_q == OP_DCX);
    assign accept  = (state_q == S_IDLE) && op_stb_i;

    // Byte ALU; subtraction borrow appears as the extra top bit.
    logic [DATASIZE:0]   alu_sum;
    logic [4:0]          alu_nib;
    logic                alu_cin, alu_ac, alu_c;
    logic [DATASIZE-1:0] alu_res;

    always_comb begin
        alu_cin = ((cod_q == OP_ADC) || (cod_q == OP_SBB)) ? flg[0] : 1'b0;
        alu_sum = '0;
        alu_nib = '0;
        alu_res = '0;
        alu_ac  = 1'b0;
        alu_c   = 1'b0;
        case (cod_q)
            OP_ADD, OP_ADC: begin
                alu_sum = {1'b0, acc} + {1'b0, op2} + {{DATASIZE{1'b0}}, alu_cin};
                alu_nib = {1'b0, acc[3:0]} + {1'b0, op2[3:0]} + {4'd0, alu_cin};
                alu_res = alu_sum[DATASIZE-1:0];
                alu_ac  = alu_nib[4];
                alu_c   = alu_sum[DATASIZE];
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                alu_sum = {1'b0, acc} - {1'b0, op2} - {{DATASIZE{1'b0}}, alu_cin};
                alu_nib = {1'b0, acc[3:0]} - {1'b0, op2[3:0]} - {4'd0, alu_cin};
                alu_res = alu_sum[DATASIZE-1:0];
                alu_ac  = alu_nib[4];
                alu_c   = alu_sum[DATASIZE];
            end
            OP_AND:  alu_res = acc & op2;
            OP_XOR:  alu_res = acc ^ op2;
            OP_OR:   alu_res = acc | op2;
            default: alu_res = '0;
        endcase
    end

`ifdef ALUREG_SEQ_DAA_EN
    // Decimal adjust: +6 on the low nibble, then +0x60 when the adjusted
    // high nibble overflows or a carry is already pending.
    logic [4:0]          daa_nib;
    logic [8:0]          daa_t;
    logic [7:0]          daa_adj;
    logic                daa_lo, daa_hi, daa_ac;
    logic [DATASIZE-1:0] daa_res;

    always_comb begin
        daa_lo  = (acc[3:0] > 4'd9) | flg[4];
        daa_nib = {1'b0, acc[3:0]} + 5'd6;
        daa_ac  = daa_lo & daa_nib[4];
        daa_t   = {1'b0, acc[7:0]} + (daa_lo ? 9'd6 : 9'd0);
        daa_hi  = flg[0] | daa_t[8] | (daa_t[7:4] > 4'd9);
        daa_adj = {1'b0, daa_hi, daa_hi, 2'b00, daa_lo, daa_lo, 1'b0};
        daa_res = acc + DATASIZE'(daa_adj);
    end
`endif

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        wr_en   = 1'b0;
        wr_idx  = dst_q;
        wr_dat  = '0;
        fl_en   = 1'b0;
        fl_dat  = flg;
        lo_sum  = '0;
        hi_sum  = '0;
        case (state_q)
            S_IDLE: begin
                // A simultaneous op request takes priority over the bus load.
                if (op_stb_i) begin
                    state_d = S_EXLO;
                end else if (ext_wr_i) begin
                    wr_en  = 1'b1;
                    wr_idx = ext_sel_i;
                    wr_dat = ext_dat_i;
                end
            end
            S_EXLO: begin
                state_d = is_pair ? S_EXHI : S_IDLE;
                case (cod_q)
                    OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_XOR, OP_OR: begin
                        wr_en  = 1'b1;
                        wr_idx = IDX_A;
                        wr_dat = alu_res;
                        fl_en  = 1'b1;
                        fl_dat = mk_flags(alu_res, alu_ac, alu_c);
                    end
                    OP_CMP: begin
                        fl_en  = 1'b1;
                        fl_dat = mk_flags(alu_res, alu_ac, alu_c);
                    end
                    OP_MOV: begin
                        wr_en  = 1'b1;
                        wr_dat = op2;
                    end
                    OP_INR: begin
                        wr_en  = 1'b1;
                        wr_dat = dst_val + DATASIZE'(1);
                        fl_en  = 1'b1;
                        fl_dat = mk_flags(wr_dat, dst_val[3:0] == 4'hF, flg[0]);
                    end
                    OP_DCR: begin
                        wr_en  = 1'b1;
                        wr_dat = dst_val - DATASIZE'(1);
                        fl_en  = 1'b1;
                        fl_dat = mk_flags(wr_dat, dst_val[3:0] == 4'h0, flg[0]);
                    end
                    OP_DAD: begin
                        lo_sum  = {1'b0, regs_q[IDX_L]} + {1'b0, lo_val};
                        carry_d = lo_sum[DATASIZE];
                        wr_en   = !pair_fa;
                        wr_idx  = IDX_L;
                        wr_dat  = lo_sum[DATASIZE-1:0];
                    end
                    OP_INX, OP_DCX: begin
                        // Top bit is the carry (INX) or borrow (DCX) into the high byte.
                        lo_sum  = (cod_q == OP_INX) ? ({1'b0, lo_val} + (DATASIZE+1)'(1))
                                                    : ({1'b0, lo_val} - (DATASIZE+1)'(1));
                        carry_d = lo_sum[DATASIZE];
                        wr_en   = !pair_fa;
                        wr_idx  = idx_lo;
                        wr_dat  = lo_sum[DATASIZE-1:0];
                    end
`ifdef ALUREG_SEQ_DAA_EN
                    OP_DAA: begin
                        wr_en  = 1'b1;
                        wr_idx = IDX_A;
                        wr_dat = daa_res;
                        fl_en  = 1'b1;
                        fl_dat = mk_flags(daa_res, daa_ac, daa_hi);
                    end
`endif
                    default: ;
                endcase
            end
            S_EXHI: begin
                state_d = S_IDLE;
                case (cod_q)
                    OP_DAD: begin
                        hi_sum = {1'b0, regs_q[IDX_H]} + {1'b0, hi_val}
                               + {{DATASIZE{1'b0}}, carry_q};
                        wr_en  = !pair_fa;
                        wr_idx = IDX_H;
                        wr_dat = hi_sum[DATASIZE-1:0];
                        fl_en  = !pair_fa;
                        fl_dat = {flg[DATASIZE-1:1], hi_sum[DATASIZE]};
                    end
                    OP_INX, OP_DCX: begin
                        hi_sum = (cod_q == OP_INX)
                               ? ({1'b0, hi_val} + {{DATASIZE{1'b0}}, carry_q})
                               : ({1'b0, hi_val} - {{DATASIZE{1'b0}}, carry_q});
                        wr_en  = !pair_fa;
                        wr_idx = idx_hi;
                        wr_dat = hi_sum[DATASIZE-1:0];
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
        if (wr_en && (wr_idx == IDX_F)) begin
            wr_dat = wr_dat & FLAG_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cod_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            imm_q   <= '0;
            uim_q   <= 1'b0;
            carry_q <= 1'b0;
            for (int i = 0; i < REGCOUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            if (accept) begin
                cod_q <= op_cod_i;
                dst_q <= op_dst_i;
                src_q <= op_src_i;
                imm_q <= op_imm_i;
                uim_q <= op_uim_i;
            end
            // Flag update follows the data write so flags win when dst is F.
            if (wr_en) regs_q[wr_idx] <= wr_dat;
            if (fl_en) regs_q[IDX_F]  <= fl_dat;
        end
    end

    assign rd_dat_o  = regs_q[rd_sel_i];
    assign flag_q_o  = flg;
    assign op_rdy_o  = (state_q == S_IDLE);
    assign op_done_o = ((state_q == S_EXLO) && !is_pair) || (state_q == S_EXHI);

endmodule
`default_nettype wire
